stopwatch_time_counter: RTL and testbench

//  Stopwatch timebase core: counts MM:SS.CC (centiseconds) in packed BCD on a 100 Hz tick.

---
 rtl/stopwatch_pkg.sv | 11 +
 rtl/bcd_digit_inc.sv | 44 ++++
 rtl/stopwatch_time_counter.sv | 128 ++++++++++++
 tb/tb_stopwatch_time_counter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and digit limits for the MM:SS.CC stopwatch timebase.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} sw_state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t DIGIT9 = 4'd9;
    localparam bcd_t DIGIT5 = 4'd5;

endpackage

// File: rtl/bcd_digit_inc.sv
// One BCD digit of the stopwatch: adds carry-in through a 4-bit full-adder ripple,
// wraps past 'lim' with carry-out, and scrubs any out-of-range digit to 0.
module bcd_digit_inc
    import stopwatch_pkg::*;
(
    input  bcd_t d,
    input  logic cin,
    input  bcd_t lim,
    output bcd_t q,
    output logic cout
);

    logic [4:0] c;
    logic [3:0] s;
    logic [3:0] b_op;
    logic       illegal;
    logic       wrap;

    assign b_op = 4'b0000;
    assign c[0] = cin;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign s[gi]     = d[gi] ^ b_op[gi] ^ c[gi];
            assign c[gi + 1] = (d[gi] & b_op[gi]) | (c[gi] & (d[gi] ^ b_op[gi]));
        end
    endgenerate

    assign illegal = (d > lim);
    assign wrap    = ({c[4], s} > {1'b0, lim});

    // An illegal digit is cleared without producing a carry.
    always_comb begin
        q    = s;
        cout = 1'b0;
        if (illegal) begin
            q = 4'd0;
        end else if (wrap) begin
            q    = 4'd0;
            cout = 1'b1;
        end
    end

endmodule

// File: rtl/stopwatch_time_counter.sv
// Stopwatch timebase: IDLE/RUN/PAUSE control and a six-digit BCD MM:SS.CC count on a 100 Hz tick.
// Optional lap display freeze is built when LAP_HOLD_EN is defined.
module stopwatch_time_counter
    import stopwatch_pkg::*;
#(
    parameter int MIN_TENS_MAX = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [23:0] digits,
    output logic        running,
    output logic        overflow
);

    sw_state_t   state_q, state_d;
    logic [23:0] cnt_q, cnt_d;
    logic        running_q, running_d;
    logic        overflow_q, overflow_d;
    logic [23:0] inc_cnt;
    logic [6:0]  carry;

    // Digit 0 is centiseconds-ones, digit 5 is minutes-tens.
    assign carry[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_digit
            localparam bcd_t LIM = (gi == 3) ? DIGIT5 :
                                   (gi == 5) ? bcd_t'(MIN_TENS_MAX) : DIGIT9;
            bcd_digit_inc u_digit (
                .d    (cnt_q[gi*4 +: 4]),
                .cin  (carry[gi]),
                .lim  (LIM),
                .q    (inc_cnt[gi*4 +: 4]),
                .cout (carry[gi + 1])
            );
        end
    endgenerate

`ifdef LAP_HOLD_EN
    logic        hold_q, hold_d;
    logic [23:0] snap_q, snap_d;
`else
    logic unused_lap;
    assign unused_lap = lap;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        overflow_d = 1'b0;
`ifdef LAP_HOLD_EN
        hold_d     = hold_q;
        snap_d     = snap_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_stop) state_d = RUN;
            end
            RUN: begin
                // A full carry chain leaves every digit at 0, which is the wrap value.
                if (tick) begin
                    cnt_d      = inc_cnt;
                    overflow_d = carry[6];
                end
`ifdef LAP_HOLD_EN
                if (lap) begin
                    hold_d = !hold_q;
                    if (!hold_q) snap_d = cnt_q;
                end
`endif
                if (start_stop) begin
                    state_d = PAUSE;
`ifdef LAP_HOLD_EN
                    hold_d  = 1'b0;
`endif
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_d = IDLE;
                    cnt_d   = '0;
`ifdef LAP_HOLD_EN
                    hold_d  = 1'b0;
`endif
                end else if (start_stop) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
`ifdef LAP_HOLD_EN
            hold_q     <= 1'b0;
            snap_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            running_q  <= running_d;
            overflow_q <= overflow_d;
`ifdef LAP_HOLD_EN
            hold_q     <= hold_d;
            snap_q     <= snap_d;
`endif
        end
    end

`ifdef LAP_HOLD_EN
    assign digits = hold_q ? snap_q : cnt_q;
`else
    assign digits = cnt_q;
`endif
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_time_counter.sv
// Bench for stopwatch_time_counter: centisecond-integer reference model checked every cycle,
// plus literal checkpoints. Minutes-tens limit is 0 here so a full wrap stays short.
module tb_stopwatch_time_counter;

    localparam int MTM  = 0;
    localparam int WRAP = (MTM + 1) * 60000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tick = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [23:0] digits;
    logic        running;
    logic        overflow;

    int total = 0;
    int bad = 0;

    // reference model: 0=idle 1=run 2=pause, count in centiseconds
    int m_st = 0;
    int m_cs = 0;
    bit m_ovf = 1'b0;
    bit m_hold = 1'b0;
    int m_snap = 0;

    stopwatch_time_counter #(.MIN_TENS_MAX(MTM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .tick       (tick),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .digits     (digits),
        .running    (running),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] to_bcd(input int cs);
        logic [23:0] r;
        r[3:0]   = 4'(cs % 10);
        r[7:4]   = 4'((cs / 10) % 10);
        r[11:8]  = 4'((cs / 100) % 10);
        r[15:12] = 4'((cs / 1000) % 6);
        r[19:16] = 4'((cs / 6000) % 10);
        r[23:20] = 4'(cs / 60000);
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_st = 0; m_cs = 0; m_ovf = 1'b0; m_hold = 1'b0; m_snap = 0;
            end else begin
                m_ovf = 1'b0;
                if (m_st == 1) begin
`ifdef LAP_HOLD_EN
                    if (lap) begin
                        if (m_hold) m_hold = 1'b0;
                        else begin m_hold = 1'b1; m_snap = m_cs; end
                    end
`endif
                    if (tick) begin
                        m_cs = m_cs + 1;
                        if (m_cs == WRAP) begin m_cs = 0; m_ovf = 1'b1; end
                    end
                    if (start_stop) begin m_st = 2; m_hold = 1'b0; end
                end else if (m_st == 2) begin
                    if (clear) begin m_st = 0; m_cs = 0; m_hold = 1'b0; end
                    else if (start_stop) m_st = 1;
                end else if (start_stop) begin
                    m_st = 1;
                end
            end
        end
    end

    initial begin
        logic [23:0] exp_d;
        forever begin
            @(negedge clk);
            exp_d = m_hold ? to_bcd(m_snap) : to_bcd(m_cs);
            total += 3;
            if (digits !== exp_d) begin
                bad++;
                $display("FAIL cyc_digits t=%0t got %h want %h", $time, digits, exp_d);
            end
            if (running !== (m_st == 1)) begin
                bad++;
                $display("FAIL cyc_running t=%0t got %b want %b", $time, running, (m_st == 1));
            end
            if (overflow !== m_ovf) begin
                bad++;
                $display("FAIL cyc_overflow t=%0t got %b want %b", $time, overflow, m_ovf);
            end
        end
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic step(input logic ss, input logic clr, input logic tk, input logic lp);
        start_stop = ss; clear = clr; tick = tk; lap = lp;
        @(posedge clk);
        #1;
        start_stop = 1'b0; clear = 1'b0; tick = 1'b0; lap = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_digits", digits, 24'h000000);
        check("reset_running", {23'd0, running}, 24'd0);
        check("reset_overflow", {23'd0, overflow}, 24'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // start and tick together from IDLE: tick not counted
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("edge_tick_digits", digits, 24'h000000);
        check("edge_tick_running", {23'd0, running}, 24'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("edge_next_tick", digits, 24'h000001);

        // pause then clear back to IDLE
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_from_pause", digits, 24'h000000);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(100);
        check("count_100", digits, 24'h000100);
        check("count_running", {23'd0, running}, 24'd1);

        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("run_clear_ignored", digits, 24'h000100);

        // tick with start_stop in RUN: counted, then PAUSE
        ticks(220);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        check("pause_at_321", digits, 24'h000321);
        check("pause_running", {23'd0, running}, 24'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("pause_holds", digits, 24'h000321);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check("clear_wins_digits", digits, 24'h000000);
        check("clear_wins_running", {23'd0, running}, 24'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_clear", {23'd0, running}, 24'd0);

        // lap behaviour
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(250);
        check("lap_base", digits, 24'h000250);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        ticks(30);
`ifdef LAP_HOLD_EN
        check("lap_held", digits, 24'h000250);
`else
        check("lap_ignored", digits, 24'h000280);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("lap_release", digits, 24'h000280);

        // async reset mid-count, no clock edge in between
        ticks(954);
        check("pre_reset", digits, 24'h001234);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_digits", digits, 24'h000000);
        check("async_reset_running", {23'd0, running}, 24'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // rollovers
        step(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(5999);
        check("at_5999", digits, 24'h005999);
        ticks(1);
        check("minute_roll", digits, 24'h010000);
        ticks(WRAP - 1 - 6000);
        check("at_max", digits, 24'h095999);
        ticks(1);
        check("wrap_digits", digits, 24'h000000);
        check("wrap_overflow", {23'd0, overflow}, 24'd1);
        check("wrap_running", {23'd0, running}, 24'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        check("overflow_one_cycle", {23'd0, overflow}, 24'd0);
        ticks(1);
        check("after_wrap", digits, 24'h000001);

        step(1'b0, 1'b0, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
